mmu_utlb_top: RTL and testbench
===============================

# mmu_utlb_top

Parametrised memory-management unit for the CPU pipeline, successor to the single-cycle fully-combinational MMU. It translates instruction-fetch and data-access virtual addresses through the fixed MIPS segment map, a per-channel one-entry micro-TLB and a shared, parametrised joint TLB. A micro-TLB miss stalls the requesting channel while a refill state machine searches the joint TLB. It also services CP0 TLB instructions (tlbp, tlbr, tlbwi/tlbwr).

## Interface
- TLB_ENTRIES, 16, joint TLB entry count (power of two, 4..64); IDX_W = log2(TLB_ENTRIES)
- ASID_W, 8, address-space ID width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- user_mode  in  1  CPU in user mode
- asid  in  ASID_W  current EntryHi.ASID
- i_req, d_req  in  1  channel request, held stable with address until ready
- i_vaddr, d_vaddr  in  32  virtual address
- d_we  in  1  data access is a store
- i_ready, d_ready  out  1  response valid this cycle
- i_paddr, d_paddr  out  32  physical address
- i_uncached, d_uncached  out  1  uncached access
- i_exp_illegal, d_exp_illegal  out  1  address error (segment protection)
- i_exp_miss, d_exp_miss  out  1  TLB refill exception
- i_exp_invalid, d_exp_invalid  out  1  TLB invalid exception
- d_exp_mod  out  1  TLB modified exception (store to D=0 page)
- tlb_we  in  1  write entry (tlbwi/tlbwr; CP0 supplies index)
- tlb_index  in  IDX_W  entry index for write/read
- entry_hi  in  32  VPN2[31:13], ASID[ASID_W-1:0]
- entry_lo0, entry_lo1  in  32  PFN[25:6], C[5:3], D[2], V[1], G[0]
- tlbp  in  1  probe request using entry_hi
- tlbp_valid  out  1  probe result valid
- tlbp_result  out  32  bit31 = not found, [IDX_W-1:0] = matching index
- tlbr_hi, tlbr_lo0, tlbr_lo1  out  32  entry at tlb_index (combinational read)

## Operation
- Segment map per channel: kuseg 0x0000_0000-0x7FFF_FFFF mapped; kseg0 0x8000_0000-0x9FFF_FFFF unmapped cached, paddr = vaddr & 0x1FFF_FFFF; kseg1 0xA000_0000-0xBFFF_FFFF unmapped uncached, same mask; kseg2/3 ≥0xC000_0000 mapped. user_mode and vaddr[31]=1 → exp_illegal.
- Unmapped or illegal: ready = req in the same cycle, no stall.
- Micro-TLB entry: valid, VPN[31:12], ASID, G, PFN, C, D, V. Hit = valid && VPN match && (G || ASID match). On hit: ready same cycle; paddr = {PFN[19:0], vaddr[11:0]}; uncached = (C == 2); V=0 → exp_invalid; d_we && D=0 → d_exp_mod.
- Micro-TLB miss on a mapped address: ready=0, channel enters refill arbitration.
- Refill FSM states: IDLE → LOOKUP → FILL → IDLE. IDLE: pick missing channel, data has priority over inst, latch its vaddr. LOOKUP: compare all entries (VPN2 = vaddr[31:13], G or ASID match), register hit and index. FILL, on hit: write even/odd half selected by vaddr[12] into that channel's micro-TLB. FILL, on no hit: pulse ready with exp_miss=1 for that channel, micro-TLB unchanged.
- Multiple hits in the joint TLB: lowest index wins.
- Flush (all micro-TLB valid bits cleared): on tlb_we, and on asid change vs. the previous cycle's value.
- tlb_we: writes entry tlb_index at the clock edge. G stored = lo0.G & lo1.G.
- tlbp: one lookup against entry_hi, result registered.

## Timing
- Reset: all micro-TLB and joint TLB valid/V bits cleared, FSM IDLE, all ready/exp outputs 0, paddr 0, tlbp_valid 0, tlbp_result 0.
- Micro-TLB miss latency: miss seen in cycle 0 → LOOKUP in cycle 1 → FILL in cycle 2 → hit with ready=1 in cycle 3. Refill-miss exception: ready+exp_miss in cycle 2.
- Both channels miss in the same cycle: data refill is served first; inst refill starts in the cycle after data FILL.
- tlb_we or an asid change while the FSM is in LOOKUP/FILL: refill is aborted, FSM goes to IDLE, no fill, no exception; the request restarts from the micro-TLB.
- A hit response in the same cycle as a flush uses the old entry; the flush takes effect next cycle.
- tlbp: tlbp_valid=1 with tlbp_result one cycle after tlbp. tlbp in the same cycle as tlb_we sees the old contents.
- req dropped mid-refill: the refill completes and the fill is kept, but no response is given.
- rst_n low in any state: next edge returns to the reset state.

## Test plan
- Reset, then d_req at 0x8000_1234 kernel mode → same-cycle d_ready, d_paddr=0x0000_1234, uncached=0; 0xA000_0010 → paddr 0x0000_0010, uncached=1.
- user_mode=1, i_req at 0x8000_0000 → i_ready with i_exp_illegal=1, no stall.
- Write entry 3: VPN2 0x00400>>1, ASID 5, lo0 PFN 0x12 V=1 D=0, lo1 PFN 0x34 V=1 D=1; asid=5, d_req 0x0040_1ABC load → d_ready in cycle 3, paddr 0x0003_4ABC; a repeat access hits in 0 cycles; a store to 0x0040_0000 → d_exp_mod=1.
- Empty TLB, d_req 0x0000_5000 → d_ready with d_exp_miss in cycle 2; simultaneous i/d misses → data served first, inst exp_miss 3 cycles later.
- After a micro-TLB fill, change asid to 6 (non-global entry) → next access misses and refills again; tlb_we during LOOKUP → aborted, then correct retry.
- tlbp with a matching entry_hi → tlbp_result=3 next cycle; with no match → 0x8000_0000.

Source files
------------

// File: rtl/mmu_utlb_top.sv
// MMU: fixed MIPS segment map, per-channel one-entry micro-TLB, shared joint TLB
// with a refill FSM, plus CP0 tlbp/tlbr/tlbw access.
package mmu_utlb_pkg;
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } pte_t;
endpackage

module mmu_utlb_chan
  import mmu_utlb_pkg::*;
#(
  parameter int ASID_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              user_mode_i,
  input  logic              we_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic [31:0]       vaddr_i,
  input  logic              flush_i,
  input  logic              fill_i,
  input  logic [19:0]       fill_vpn_i,
  input  pte_t              fill_pte_i,
  input  logic              fill_g_i,
  input  logic              rmiss_i,
  output logic              miss_o,
  output logic              ready_o,
  output logic [31:0]       paddr_o,
  output logic              uncached_o,
  output logic              exp_illegal_o,
  output logic              exp_miss_o,
  output logic              exp_invalid_o,
  output logic              exp_mod_o
);
  logic              vld_q, g_q;
  logic [19:0]       vpn_q;
  logic [ASID_W-1:0] asid_q;
  pte_t              pte_q;
  logic              illegal, unmapped, hit;

  // Flush and fill never coincide: the FSM aborts a fill whenever a flush fires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      g_q    <= 1'b0;
      vpn_q  <= '0;
      asid_q <= '0;
      pte_q  <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (fill_i) begin
      vld_q  <= 1'b1;
      g_q    <= fill_g_i;
      vpn_q  <= fill_vpn_i;
      asid_q <= asid_i;
      pte_q  <= fill_pte_i;
    end
  end

  assign illegal  = user_mode_i & vaddr_i[31];
  assign unmapped = (vaddr_i[31:30] == 2'b10);
  assign hit      = vld_q && (vpn_q == vaddr_i[31:12]) && (g_q || asid_q == asid_i);
  assign miss_o   = rst_n && req_i && !illegal && !unmapped && !hit;

  always_comb begin
    ready_o       = 1'b0;
    paddr_o       = '0;
    uncached_o    = 1'b0;
    exp_illegal_o = 1'b0;
    exp_miss_o    = 1'b0;
    exp_invalid_o = 1'b0;
    exp_mod_o     = 1'b0;
    if (rst_n && req_i) begin
      if (illegal) begin
        ready_o       = 1'b1;
        exp_illegal_o = 1'b1;
      end else if (unmapped) begin
        ready_o    = 1'b1;
        paddr_o    = {3'b000, vaddr_i[28:0]};
        uncached_o = vaddr_i[29];
      end else if (hit) begin
        ready_o       = 1'b1;
        paddr_o       = {pte_q.pfn, vaddr_i[11:0]};
        uncached_o    = (pte_q.c == 3'd2);
        exp_invalid_o = !pte_q.v;
        exp_mod_o     = we_i && pte_q.v && !pte_q.d;
      end else if (rmiss_i) begin
        ready_o    = 1'b1;
        exp_miss_o = 1'b1;
      end
    end
  end
endmodule

module mmu_utlb_top
  import mmu_utlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int ASID_W      = 8,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              user_mode,
  input  logic [ASID_W-1:0] asid,
  input  logic              i_req,
  input  logic              d_req,
  input  logic [31:0]       i_vaddr,
  input  logic [31:0]       d_vaddr,
  input  logic              d_we,
  output logic              i_ready,
  output logic              d_ready,
  output logic [31:0]       i_paddr,
  output logic [31:0]       d_paddr,
  output logic              i_uncached,
  output logic              d_uncached,
  output logic              i_exp_illegal,
  output logic              d_exp_illegal,
  output logic              i_exp_miss,
  output logic              d_exp_miss,
  output logic              i_exp_invalid,
  output logic              d_exp_invalid,
  output logic              d_exp_mod,
  input  logic              tlb_we,
  input  logic [IDX_W-1:0]  tlb_index,
  input  logic [31:0]       entry_hi,
  input  logic [31:0]       entry_lo0,
  input  logic [31:0]       entry_lo1,
  input  logic              tlbp,
  output logic              tlbp_valid,
  output logic [31:0]       tlbp_result,
  output logic [31:0]       tlbr_hi,
  output logic [31:0]       tlbr_lo0,
  output logic [31:0]       tlbr_lo1
);
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL} state_e;

  logic [TLB_ENTRIES-1:0]             jv_q, jg_q;
  logic [TLB_ENTRIES-1:0][18:0]       jvpn_q;
  logic [TLB_ENTRIES-1:0][ASID_W-1:0] jasid_q;
  pte_t [TLB_ENTRIES-1:0]             jlo0_q, jlo1_q;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;       // 1 = data channel
  logic [31:12]      va_q, va_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ASID_W-1:0] asid_q;
  logic              tlbp_valid_q;
  logic [31:0]       tlbp_result_q;

  logic              flush, lk_hit, pb_hit;
  logic [IDX_W-1:0]  lk_idx, pb_idx;
  pte_t              fill_pte;
  logic [1:0]        req_w, we_w, miss_w, fill_w, rmiss_w;
  logic [1:0]        rdy_w, unc_w, ill_w, xmiss_w, inv_w, mod_w;
  logic [1:0][31:0]  va_w, pa_w;
  logic              unused_ok;

  assign flush = tlb_we | (asid != asid_q);

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    pb_hit = 1'b0;
    pb_idx = '0;
    for (int k = TLB_ENTRIES - 1; k >= 0; k--) begin
      if (jv_q[k] && jvpn_q[k] == va_q[31:13] && (jg_q[k] || jasid_q[k] == asid)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(k);
      end
      if (jv_q[k] && jvpn_q[k] == entry_hi[31:13] &&
          (jg_q[k] || jasid_q[k] == entry_hi[ASID_W-1:0])) begin
        pb_hit = 1'b1;
        pb_idx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jv_q    <= '0;
      jg_q    <= '0;
      jvpn_q  <= '0;
      jasid_q <= '0;
      jlo0_q  <= '0;
      jlo1_q  <= '0;
    end else if (tlb_we) begin
      jv_q[tlb_index]    <= 1'b1;
      jg_q[tlb_index]    <= entry_lo0[0] & entry_lo1[0];
      jvpn_q[tlb_index]  <= entry_hi[31:13];
      jasid_q[tlb_index] <= entry_hi[ASID_W-1:0];
      jlo0_q[tlb_index]  <= pte_t'(entry_lo0[25:1]);
      jlo1_q[tlb_index]  <= pte_t'(entry_lo1[25:1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_q         <= 1'b0;
      va_q          <= '0;
      hit_q         <= 1'b0;
      idx_q         <= '0;
      asid_q        <= '0;
      tlbp_valid_q  <= 1'b0;
      tlbp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      va_q         <= va_d;
      hit_q        <= hit_d;
      idx_q        <= idx_d;
      asid_q       <= asid;
      tlbp_valid_q <= tlbp;
      if (tlbp) tlbp_result_q <= pb_hit ? 32'(pb_idx) : 32'h8000_0000;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    va_d    = va_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    fill_w  = '0;
    rmiss_w = '0;
    case (state_q)
      S_IDLE: begin
        if (miss_w[1]) begin
          sel_d   = 1'b1;
          va_d    = d_vaddr[31:12];
          state_d = S_LOOKUP;
        end else if (miss_w[0]) begin
          sel_d   = 1'b0;
          va_d    = i_vaddr[31:12];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d   = lk_hit;
        idx_d   = lk_idx;
        state_d = flush ? S_IDLE : S_FILL;
      end
      S_FILL: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (hit_q) fill_w[sel_q]  = 1'b1;
          else       rmiss_w[sel_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fill_pte = va_q[12] ? jlo1_q[idx_q] : jlo0_q[idx_q];
  assign req_w    = {d_req, i_req};
  assign we_w     = {d_we, 1'b0};
  assign va_w     = {d_vaddr, i_vaddr};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    mmu_utlb_chan #(.ASID_W(ASID_W)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_w[ch]),
      .user_mode_i  (user_mode),
      .we_i         (we_w[ch]),
      .asid_i       (asid),
      .vaddr_i      (va_w[ch]),
      .flush_i      (flush),
      .fill_i       (fill_w[ch]),
      .fill_vpn_i   (va_q[31:12]),
      .fill_pte_i   (fill_pte),
      .fill_g_i     (jg_q[idx_q]),
      .rmiss_i      (rmiss_w[ch]),
      .miss_o       (miss_w[ch]),
      .ready_o      (rdy_w[ch]),
      .paddr_o      (pa_w[ch]),
      .uncached_o   (unc_w[ch]),
      .exp_illegal_o(ill_w[ch]),
      .exp_miss_o   (xmiss_w[ch]),
      .exp_invalid_o(inv_w[ch]),
      .exp_mod_o    (mod_w[ch])
    );
  end

  assign {d_ready, i_ready}             = rdy_w;
  assign {d_paddr, i_paddr}             = pa_w;
  assign {d_uncached, i_uncached}       = unc_w;
  assign {d_exp_illegal, i_exp_illegal} = ill_w;
  assign {d_exp_miss, i_exp_miss}       = xmiss_w;
  assign {d_exp_invalid, i_exp_invalid} = inv_w;
  assign d_exp_mod                      = mod_w[1];

  assign tlbp_valid  = tlbp_valid_q;
  assign tlbp_result = tlbp_result_q;
  assign tlbr_hi     = {jvpn_q[tlb_index], 13'(jasid_q[tlb_index])};
  assign tlbr_lo0    = {6'b0, jlo0_q[tlb_index], jg_q[tlb_index]};
  assign tlbr_lo1    = {6'b0, jlo1_q[tlb_index], jg_q[tlb_index]};

  // Instruction fetch never stores; reserved CP0 register bits are ignored.
  assign unused_ok = ^{mod_w[0], entry_hi[12:ASID_W], entry_lo0[31:26], entry_lo1[31:26]};
endmodule

// File: tb/tb_mmu_utlb_top.sv
// Directed bench for mmu_utlb_top: segment map, refill latency, exceptions, flushes, CP0 ops.
module tb_mmu_utlb_top;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        user_mode;
  logic [7:0]  asid;
  logic        i_req, d_req, d_we;
  logic [31:0] i_vaddr, d_vaddr;
  logic        i_ready, d_ready, i_uncached, d_uncached;
  logic [31:0] i_paddr, d_paddr;
  logic        i_exp_illegal, d_exp_illegal, i_exp_miss, d_exp_miss;
  logic        i_exp_invalid, d_exp_invalid, d_exp_mod;
  logic        tlb_we, tlbp, tlbp_valid;
  logic [3:0]  tlb_index;
  logic [31:0] entry_hi, entry_lo0, entry_lo1;
  logic [31:0] tlbp_result, tlbr_hi, tlbr_lo0, tlbr_lo1;

  int total = 0, bad = 0;
  int cd, ci;
  logic [31:0] dp_c, ip_c;
  logic        dm_c, dmod_c, dinv_c, dunc_c, im_c;

  always #5 clk = ~clk;

  mmu_utlb_top #(.TLB_ENTRIES(16), .ASID_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .user_mode(user_mode), .asid(asid),
    .i_req(i_req), .d_req(d_req), .i_vaddr(i_vaddr), .d_vaddr(d_vaddr), .d_we(d_we),
    .i_ready(i_ready), .d_ready(d_ready), .i_paddr(i_paddr), .d_paddr(d_paddr),
    .i_uncached(i_uncached), .d_uncached(d_uncached),
    .i_exp_illegal(i_exp_illegal), .d_exp_illegal(d_exp_illegal),
    .i_exp_miss(i_exp_miss), .d_exp_miss(d_exp_miss),
    .i_exp_invalid(i_exp_invalid), .d_exp_invalid(d_exp_invalid), .d_exp_mod(d_exp_mod),
    .tlb_we(tlb_we), .tlb_index(tlb_index), .entry_hi(entry_hi),
    .entry_lo0(entry_lo0), .entry_lo1(entry_lo1), .tlbp(tlbp),
    .tlbp_valid(tlbp_valid), .tlbp_result(tlbp_result),
    .tlbr_hi(tlbr_hi), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tlb_write(input logic [3:0] idx, input logic [31:0] hi, lo0, lo1);
    tlb_we = 1'b1; tlb_index = idx; entry_hi = hi; entry_lo0 = lo0; entry_lo1 = lo1;
    step();
    tlb_we = 1'b0;
  endtask

  // Cycle 0 is the cycle the request was raised in; -1 means no response within budget.
  task automatic wait_rdy(input bit wd, input bit wi, output int rd, output int ri);
    rd = -1; ri = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wd && rd < 0 && d_ready) begin
        rd = c; dp_c = d_paddr; dm_c = d_exp_miss; dmod_c = d_exp_mod;
        dinv_c = d_exp_invalid; dunc_c = d_uncached; d_req = 1'b0;
      end
      if (wi && ri < 0 && i_ready) begin
        ri = c; ip_c = i_paddr; im_c = i_exp_miss; i_req = 1'b0;
      end
      if ((!wd || rd >= 0) && (!wi || ri >= 0)) break;
      @(posedge clk); #1;
    end
    d_req = 1'b0; i_req = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; user_mode = 1'b0; asid = 8'd0;
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; i_vaddr = '0; d_vaddr = 32'h8000_0000;
    tlb_we = 1'b0; tlbp = 1'b0; tlb_index = '0; entry_hi = '0; entry_lo0 = '0; entry_lo1 = '0;
    step(); step();
    @(negedge clk);
    chk("rst_d_ready", {31'b0, d_ready}, 32'd0);
    chk("rst_d_paddr", d_paddr, 32'd0);
    d_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rst_tlbp_valid", {31'b0, tlbp_valid}, 32'd0);
    chk("rst_tlbp_result", tlbp_result, 32'd0);
    chk("rst_i_ready", {31'b0, i_ready}, 32'd0);

    // kseg0 / kseg1 / kseg0 on the fetch side
    step();
    d_req = 1'b1; d_vaddr = 32'h8000_1234;
    wait_rdy(1, 0, cd, ci);
    chk("kseg0_lat", cd, 32'd0);
    chk("kseg0_paddr", dp_c, 32'h0000_1234);
    chk("kseg0_unc", {31'b0, dunc_c}, 32'd0);
    d_req = 1'b1; d_vaddr = 32'hA000_0010;
    wait_rdy(1, 0, cd, ci);
    chk("kseg1_paddr", dp_c, 32'h0000_0010);
    chk("kseg1_unc", {31'b0, dunc_c}, 32'd1);
    i_req = 1'b1; i_vaddr = 32'h9FC0_0000;
    @(negedge clk);
    chk("i_kseg0_paddr", i_paddr, 32'h1FC0_0000);
    step();

    // user access to kernel space
    user_mode = 1'b1; i_vaddr = 32'h8000_0000;
    @(negedge clk);
    chk("illegal_rdy", {31'b0, i_ready}, 32'd1);
    chk("illegal_exp", {31'b0, i_exp_illegal}, 32'd1);
    i_req = 1'b0; user_mode = 1'b0;
    step();

    // empty joint TLB: refill miss
    d_req = 1'b1; d_vaddr = 32'h0000_5000;
    wait_rdy(1, 0, cd, ci);
    chk("rmiss_lat", cd, 32'd2);
    chk("rmiss_exp", {31'b0, dm_c}, 32'd1);
    step();

    // both channels miss together: data first
    d_req = 1'b1; d_vaddr = 32'h0000_5000; i_req = 1'b1; i_vaddr = 32'h0000_7000;
    wait_rdy(1, 1, cd, ci);
    chk("dual_d_lat", cd, 32'd2);
    chk("dual_i_lat", ci, 32'd5);
    chk("dual_i_exp", {31'b0, im_c}, 32'd1);
    step();

    // entry 3: VPN2 0x200, ASID 5, even PFN 0x12 D=0, odd PFN 0x34 D=1, C=3
    asid = 8'd5;
    tlb_write(4'd3, 32'h0040_0005, 32'h0000_049A, 32'h0000_0D1E);
    tlb_index = 4'd3;
    @(negedge clk);
    chk("tlbr_hi", tlbr_hi, 32'h0040_0005);
    chk("tlbr_lo0", tlbr_lo0, 32'h0000_049A);
    chk("tlbr_lo1", tlbr_lo1, 32'h0000_0D1E);
    step();

    d_req = 1'b1; d_vaddr = 32'h0040_1ABC; d_we = 1'b0;
    wait_rdy(1, 0, cd, ci);
    chk("fill_lat", cd, 32'd3);
    chk("fill_paddr", dp_c, 32'h0003_4ABC);
    chk("fill_nomiss", {31'b0, dm_c}, 32'd0);
    d_req = 1'b1;
    wait_rdy(1, 0, cd, ci);
    chk("utlb_hit_lat", cd, 32'd0);
    chk("utlb_hit_paddr", dp_c, 32'h0003_4ABC);

    d_req = 1'b1; d_vaddr = 32'h0040_0000; d_we = 1'b1;
    wait_rdy(1, 0, cd, ci);
    chk("store_lat", cd, 32'd3);
    chk("store_paddr", dp_c, 32'h0001_2000);
    chk("store_mod", {31'b0, dmod_c}, 32'd1);
    chk("store_inv", {31'b0, dinv_c}, 32'd0);
    d_we = 1'b0;

    // probe hit / miss
    tlbp = 1'b1; entry_hi = 32'h0040_0005;
    step();
    tlbp = 1'b0;
    @(negedge clk);
    chk("tlbp_valid", {31'b0, tlbp_valid}, 32'd1);
    chk("tlbp_hit", tlbp_result, 32'd3);
    step();
    @(negedge clk);
    chk("tlbp_valid_drop", {31'b0, tlbp_valid}, 32'd0);
    tlbp = 1'b1; entry_hi = 32'h0040_0006;
    step();
    tlbp = 1'b0;
    @(negedge clk);
    chk("tlbp_nohit", tlbp_result, 32'h8000_0000);
    step();

    // asid change flushes the micro-TLB
    d_req = 1'b1; d_vaddr = 32'h0040_0100;
    wait_rdy(1, 0, cd, ci);
    chk("pre_asid_lat", cd, 32'd0);
    asid = 8'd6;
    step();
    d_req = 1'b1;
    wait_rdy(1, 0, cd, ci);
    chk("asid6_lat", cd, 32'd2);
    chk("asid6_miss", {31'b0, dm_c}, 32'd1);
    asid = 8'd5;
    step();
    d_req = 1'b1;
    wait_rdy(1, 0, cd, ci);
    chk("asid5_refill_lat", cd, 32'd3);
    chk("asid5_paddr", dp_c, 32'h0001_2100);

    // tlb_we during LOOKUP aborts; request restarts
    d_req = 1'b1; d_vaddr = 32'h0040_1ABC;
    @(negedge clk);
    chk("abort_c0_rdy", {31'b0, d_ready}, 32'd0);
    step();
    tlb_write(4'd5, 32'h0E00_0005, 32'h0000_0002, 32'h0000_0002);
    wait_rdy(1, 0, cd, ci);
    chk("abort_retry_lat", cd, 32'd3);
    chk("abort_retry_paddr", dp_c, 32'h0003_4ABC);
    chk("abort_retry_nomiss", {31'b0, dm_c}, 32'd0);

    // duplicate entry at higher index: lowest index wins
    tlb_write(4'd9, 32'h0040_0005, 32'h0000_0002, 32'h0000_0002);
    tlbp = 1'b1; entry_hi = 32'h0040_0005;
    step();
    tlbp = 1'b0;
    @(negedge clk);
    chk("tlbp_lowest", tlbp_result, 32'd3);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
